// File: rtl/frame_ram_scanout.sv
// frame_ram_scanout: replays the stored prev_image frame RAM to the 320x240 vga_adapter in raster order.
// Optional feature macro SCANOUT_STALL_EN adds a `stall` input that pauses the scan.
module frame_ram_scanout #(
    parameter int H_PIXELS   = 320,
    parameter int V_PIXELS   = 240,
    parameter int ROW_STRIDE = 360,
    parameter int RD_LATENCY = 2
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        start,
`ifdef SCANOUT_STALL_EN
    input  logic        stall,
`endif
    input  logic [1:0]  chan_sel,
    output logic [16:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic [8:0]  x,
    output logic [7:0]  y,
    output logic        colour,
    output logic        plot,
    output logic        busy,
    output logic        done
);

    localparam logic [8:0]  X_LAST = 9'(H_PIXELS - 1);
    localparam logic [7:0]  Y_LAST = 8'(V_PIXELS - 1);
    localparam logic [16:0] STRIDE = 17'(ROW_STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [8:0] px;
        logic [7:0] py;
    } pix_t;

    state_t      state_q, state_d;
    logic [8:0]  sx_q, sx_d;
    logic [7:0]  sy_q, sy_d;
    logic [16:0] row_base_q, row_base_d;
    logic [16:0] addr_q, addr_d;
    pix_t        pipe_q [RD_LATENCY];
    pix_t        push_d;
    pix_t        tail;
    logic        stall_w;
    logic        in_flight;
    logic        colour_sel;

`ifdef SCANOUT_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    // The tail retires on the same edge that DRAIN exits, so only the stages ahead of it matter.
    always_comb begin
        in_flight = 1'b0;
        for (int i = 0; i < RD_LATENCY - 1; i++) begin
            in_flight = in_flight | pipe_q[i].valid;
        end
    end

    always_comb begin
        state_d    = state_q;
        sx_d       = sx_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        push_d     = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SCAN;
                    sx_d       = '0;
                    sy_d       = '0;
                    row_base_d = '0;
                    addr_d     = '0;
                end
            end
            SCAN: begin
                if (!stall_w) begin
                    push_d.valid = 1'b1;
                    push_d.px    = sx_q;
                    push_d.py    = sy_q;
                    if (sx_q == X_LAST) begin
                        sx_d       = '0;
                        row_base_d = row_base_q + STRIDE;
                        addr_d     = row_base_q + STRIDE;
                        if (sy_q == Y_LAST) begin
                            state_d    = DRAIN;
                            sy_d       = '0;
                            row_base_d = '0;
                            addr_d     = '0;
                        end else begin
                            sy_d = sy_q + 8'd1;
                        end
                    end else begin
                        sx_d   = sx_q + 9'd1;
                        addr_d = addr_q + 17'd1;
                    end
                end
            end
            DRAIN: begin
                if (!in_flight) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            sx_q       <= '0;
            sy_q       <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            pipe_q[0]  <= push_d;
            for (int i = 1; i < RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // The last pipe stage is the output register; it lines up with rd_data for the same pixel.
    assign tail = pipe_q[RD_LATENCY-1];

    always_comb begin
        colour_sel = 1'b0;
        case (chan_sel)
            2'd0:    colour_sel = rd_data[0];
            2'd1:    colour_sel = rd_data[1];
            2'd2:    colour_sel = rd_data[2];
            default: colour_sel = |rd_data;
        endcase
    end

    assign rd_addr = addr_q;
    assign plot    = tail.valid;
    assign x       = tail.valid ? tail.px : 9'd0;
    assign y       = tail.valid ? tail.py : 8'd0;
    assign colour  = tail.valid & colour_sel;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_frame_ram_scanout.sv
// Directed testbench for frame_ram_scanout: a full-size instance replays a whole frame while a
// reduced-size instance (104x52, stride 112) exercises reset abort, chan_sel, start filtering and stall.
module tb_frame_ram_scanout;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Full-size instance
    logic        resetnB = 1'b0, startB = 1'b0;
    logic [1:0]  chanB = 2'd3;
    logic [16:0] rdAddrB;
    logic [2:0]  rdDataB;
    logic [8:0]  xB;
    logic [7:0]  yB;
    logic        colourB, plotB, busyB, doneB;

    // Reduced-size instance
    logic        resetnS = 1'b0, startS = 1'b0, constS = 1'b0;
    logic [1:0]  chanS = 2'd3;
    logic [16:0] rdAddrS;
    logic [2:0]  rdDataS;
    logic [8:0]  xS;
    logic [7:0]  yS;
    logic        colourS, plotS, busyS, doneS;
`ifdef SCANOUT_STALL_EN
    logic        stallS = 1'b0;
`endif

    frame_ram_scanout u_big (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetnB),
        .start    (startB),
`ifdef SCANOUT_STALL_EN
        .stall    (1'b0),
`endif
        .chan_sel (chanB),
        .rd_addr  (rdAddrB),
        .rd_data  (rdDataB),
        .x        (xB),
        .y        (yB),
        .colour   (colourB),
        .plot     (plotB),
        .busy     (busyB),
        .done     (doneB)
    );

    frame_ram_scanout #(
        .H_PIXELS   (104),
        .V_PIXELS   (52),
        .ROW_STRIDE (112),
        .RD_LATENCY (2)
    ) u_small (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetnS),
        .start    (startS),
`ifdef SCANOUT_STALL_EN
        .stall    (stallS),
`endif
        .chan_sel (chanS),
        .rd_addr  (rdAddrS),
        .rd_data  (rdDataS),
        .x        (xS),
        .y        (yS),
        .colour   (colourS),
        .plot     (plotS),
        .busy     (busyS),
        .done     (doneS)
    );

    // Two-cycle RAM models: q = addr[2:0]; the small one can be forced to a constant 3'b100.
    logic [16:0] ramB1 = '0, ramB2 = '0, ramS1 = '0, ramS2 = '0;
    always @(posedge CLOCK_50) begin
        ramB1 <= rdAddrB;
        ramB2 <= ramB1;
        ramS1 <= rdAddrS;
        ramS2 <= ramS1;
    end
    assign rdDataB = ramB2[2:0];
    assign rdDataS = constS ? 3'b100 : ramS2[2:0];

    function automatic logic refColour(int px, int py);
        int a;
        a = py * 360 + px;
        return (a % 8) != 0;
    endfunction

    // Full-frame scoreboard for the big instance
    bit          bigArmed = 1'b0;
    int          startCycB = 0;
    int          relB;
    int          exB = 0, eyB = 0, plotsB = 0, orderErrB = 0, colErrB = 0;
    int          col10 = 2, col01 = 2, doneCntB = 0, doneRelB = -1;
    int          lastPlotRel = -1, lastPlotX = -1, lastPlotY = -1;
    logic [16:0] rdAddr321 = '0, rdAddrLast = '0;
    assign relB = cyc - startCycB;

    always @(negedge CLOCK_50) begin
        if (bigArmed) begin
            if (relB == 321) rdAddr321 <= rdAddrB;
            if (relB == 76800) rdAddrLast <= rdAddrB;
            if (doneB) begin
                doneCntB <= doneCntB + 1;
                if (doneRelB < 0) doneRelB <= relB;
            end
            if (plotB) begin
                if (xB !== 9'(exB) || yB !== 8'(eyB)) orderErrB <= orderErrB + 1;
                if (colourB !== refColour(exB, eyB)) colErrB <= colErrB + 1;
                if (xB == 9'd1 && yB == 8'd0) col10 <= int'(colourB);
                if (xB == 9'd0 && yB == 8'd1) col01 <= int'(colourB);
                lastPlotRel <= relB;
                lastPlotX   <= int'(xB);
                lastPlotY   <= int'(yB);
                plotsB      <= plotsB + 1;
                if (exB == 319) begin
                    exB <= 0;
                    eyB <= eyB + 1;
                end else begin
                    exB <= exB + 1;
                end
            end
        end
    end

    // Raster-order scoreboard for the small instance, restarted on reset or an accepted start
    int exS = 0, eyS = 0, plotsS = 0, orderErrS = 0;
    always @(negedge CLOCK_50) begin
        if (!resetnS || (startS && !busyS)) begin
            exS       <= 0;
            eyS       <= 0;
            plotsS    <= 0;
            orderErrS <= 0;
        end else if (plotS) begin
            if (xS !== 9'(exS) || yS !== 8'(eyS)) orderErrS <= orderErrS + 1;
            plotsS <= plotsS + 1;
            if (exS == 103) begin
                exS <= 0;
                eyS <= eyS + 1;
            end else begin
                exS <= exS + 1;
            end
        end
    end

    // Hold the current inputs for n clocks; returns 1 time unit after the last rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        int gap;
        int seen;

        applyStimulus(3);
        checkOutput("reset rd_addr", 32'(rdAddrB), 0);
        checkOutput("reset x", 32'(xB), 0);
        checkOutput("reset y", 32'(yB), 0);
        checkOutput("reset colour", 32'(colourB), 0);
        checkOutput("reset plot", 32'(plotB), 0);
        checkOutput("reset busy", 32'(busyB), 0);
        checkOutput("reset done", 32'(doneB), 0);
        resetnB = 1'b1;
        resetnS = 1'b1;
        applyStimulus(2);
        checkOutput("idle busy", 32'(busyB), 0);

        // Full frame on the big instance, first cycles checked directly
        startB    = 1'b1;
        startCycB = cyc;
        bigArmed  = 1'b1;
        applyStimulus(1);
        startB = 1'b0;
        checkOutput("big rel1 busy", 32'(busyB), 1);
        checkOutput("big rel1 rd_addr", 32'(rdAddrB), 0);
        checkOutput("big rel1 plot", 32'(plotB), 0);
        applyStimulus(1);
        checkOutput("big rel2 rd_addr", 32'(rdAddrB), 1);
        checkOutput("big rel2 plot", 32'(plotB), 0);
        applyStimulus(1);
        checkOutput("big rel3 plot", 32'(plotB), 1);
        checkOutput("big rel3 xy", {xB, yB}, {9'd0, 8'd0});
        checkOutput("big rel3 colour", 32'(colourB), 0);
        applyStimulus(1);
        checkOutput("big rel4 xy", {xB, yB}, {9'd1, 8'd0});
        checkOutput("big rel4 colour", 32'(colourB), 1);
        startB = 1'b1;
        applyStimulus(1);
        startB = 1'b0;

        // T1: reset the small instance at pixel (100,50)
        startS = 1'b1;
        applyStimulus(1);
        startS = 1'b0;
        applyStimulus(5300);
        checkOutput("T1 rd_addr at (100,50)", 32'(rdAddrS), 5700);
        checkOutput("T1 plot before reset", {plotS, xS, yS}, {1'b1, 9'd98, 8'd50});
        resetnS = 1'b0;
        #1;
        checkOutput("T1 rd_addr in reset", 32'(rdAddrS), 0);
        checkOutput("T1 plot/x/y in reset", {plotS, xS, yS}, 0);
        checkOutput("T1 colour/busy/done in reset", {colourS, busyS, doneS}, 0);
        applyStimulus(2);
        resetnS = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            if (doneS || busyS) seen++;
        end
        checkOutput("T1 no done after abort", seen, 0);

        // Rescan from (0,0) with constant RAM data to sweep chan_sel (T4)
        constS = 1'b1;
        chanS  = 2'd0;
        startS = 1'b1;
        applyStimulus(1);
        startS = 1'b0;
        checkOutput("T1 rescan rd_addr", 32'(rdAddrS), 0);
        checkOutput("T1 rescan busy", 32'(busyS), 1);
        applyStimulus(2);
        checkOutput("T1 rescan first plot", {plotS, xS, yS}, {1'b1, 9'd0, 8'd0});
        checkOutput("T4 chan_sel=0", 32'(colourS), 0);
        chanS = 2'd1;
        applyStimulus(1);
        checkOutput("T4 chan_sel=1", 32'(colourS), 0);
        chanS = 2'd2;
        applyStimulus(1);
        checkOutput("T4 chan_sel=2", 32'(colourS), 1);
        chanS = 2'd3;
        applyStimulus(1);
        checkOutput("T4 chan_sel=3", 32'(colourS), 1);

        // T5: start while busy, start coincident with done, then start accepted
        startS = 1'b1;
        applyStimulus(1);
        startS = 1'b0;
        applyStimulus(5403);
        checkOutput("T5 last plot", {plotS, xS, yS}, {1'b1, 9'd103, 8'd51});
        checkOutput("T5 done not early", 32'(doneS), 0);
        applyStimulus(1);
        checkOutput("T5 done", 32'(doneS), 1);
        checkOutput("T5 busy with done", 32'(busyS), 1);
        startS = 1'b1;
        applyStimulus(1);
        checkOutput("T5 start at done ignored", {busyS, doneS}, 0);
        checkOutput("T5 plot count", plotsS, 5408);
        checkOutput("T5 raster order", orderErrS, 0);
        applyStimulus(1);
        startS = 1'b0;
        checkOutput("T5 start accepted", 32'(busyS), 1);
        checkOutput("T5 restart rd_addr", 32'(rdAddrS), 0);
        resetnS = 1'b0;
        applyStimulus(2);
        resetnS = 1'b1;
        constS  = 1'b0;
        applyStimulus(1);

`ifdef SCANOUT_STALL_EN
        // T6: five stall cycles while pixel 10 is next to issue
        startS = 1'b1;
        applyStimulus(1);
        startS = 1'b0;
        applyStimulus(10);
        stallS = 1'b1;
        applyStimulus(1);
        checkOutput("T6 pixel 9 plotted", {plotS, xS, yS}, {1'b1, 9'd9, 8'd0});
        gap = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            gap += int'(plotS);
        end
        checkOutput("T6 rd_addr held", 32'(rdAddrS), 10);
        stallS = 1'b0;
        applyStimulus(1);
        gap += int'(plotS);
        checkOutput("T6 plot gap", gap, 0);
        applyStimulus(1);
        checkOutput("T6 pixel 10 plotted", {plotS, xS, yS}, {1'b1, 9'd10, 8'd0});
        applyStimulus(5397);
        checkOutput("T6 done not early", 32'(doneS), 0);
        applyStimulus(1);
        checkOutput("T6 done delayed", 32'(doneS), 1);
        checkOutput("T6 plot count", plotsS, 5408);
        checkOutput("T6 raster order", orderErrS, 0);
`endif

        // T2/T3: completion of the full-size frame
        while (cyc - startCycB < 76803) applyStimulus(1);
        checkOutput("T2 done cycle", 32'(doneB), 1);
        applyStimulus(1);
        checkOutput("T2 idle after done", {busyB, doneB}, 0);
        checkOutput("T2 plot count", plotsB, 76800);
        checkOutput("T2 raster order", orderErrB, 0);
        checkOutput("T2 colour errors", colErrB, 0);
        checkOutput("T2 colour (1,0)", col10, 1);
        checkOutput("T2 colour (0,1)", col01, 0);
        checkOutput("T2 single done", doneCntB, 1);
        checkOutput("T2 done rel", doneRelB, 76803);
        checkOutput("T3 rd_addr after row wrap", 32'(rdAddr321), 360);
        checkOutput("T3 last rd_addr", 32'(rdAddrLast), 86359);
        checkOutput("T3 last plot rel", lastPlotRel, 76802);
        checkOutput("T3 last plot xy", {lastPlotX[15:0], lastPlotY[15:0]}, {16'd319, 16'd239});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
